// File: rtl/cc_zero_countdown_ctrl.sv
// cc_zero_countdown_ctrl
// Down-counter sequencer for game timing. It loads a start value and decrements
// on each qualified tick. When the count reaches zero it raises a one-cycle done
// pulse. zero_OutLow is an active-low zero flag taken directly from the count.
// Optional feature macro: CC_ZEROCTRL_AUTORELOAD_EN. When it is defined, a
// terminal count re-enters LOAD instead of DONE, so the sequence repeats until
// abort or reset.
module cc_zero_countdown_ctrl #(
    parameter int ZEROCTRL_DATAWIDTH = 3
) (
    input  logic                          CC_ZEROCTRL_CLOCK_50,
    input  logic                          CC_ZEROCTRL_RESET_InHigh,
    input  logic                          CC_ZEROCTRL_start_In,
    input  logic                          CC_ZEROCTRL_abort_In,
    input  logic                          CC_ZEROCTRL_pause_In,
    input  logic                          CC_ZEROCTRL_tick_In,
    input  logic [ZEROCTRL_DATAWIDTH-1:0] CC_ZEROCTRL_load_InBUS,
    output logic [ZEROCTRL_DATAWIDTH-1:0] CC_ZEROCTRL_count_OutBUS,
    output logic                          CC_ZEROCTRL_busy_Out,
    output logic                          CC_ZEROCTRL_done_OutPulse,
    output logic                          CC_ZEROCTRL_zero_OutLow
);

    localparam logic [ZEROCTRL_DATAWIDTH-1:0] COUNT_ZERO = {ZEROCTRL_DATAWIDTH{1'b0}};
    localparam logic [ZEROCTRL_DATAWIDTH-1:0] COUNT_ONE  = ZEROCTRL_DATAWIDTH'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [ZEROCTRL_DATAWIDTH-1:0] count_r;
    logic [ZEROCTRL_DATAWIDTH-1:0] count_next_s;
    logic                          busy_r;
    logic                          busy_next_s;
    logic                          done_r;
    logic                          done_next_s;
    logic                          zero_low_s;

    // Active-low zero comparator on the count register. It is 0 exactly when the count is zero.
    assign zero_low_s = (count_r != COUNT_ZERO);

    // Next-state, next-count and next-output decode. Abort has the highest priority in every state.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        done_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CC_ZEROCTRL_abort_In) begin
                    state_next_s = ST_IDLE;
                end else if (CC_ZEROCTRL_start_In) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (CC_ZEROCTRL_abort_In) begin
                    state_next_s = ST_IDLE;
                end else begin
                    count_next_s = CC_ZEROCTRL_load_InBUS;
                    state_next_s = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (CC_ZEROCTRL_abort_In) begin
                    state_next_s = ST_IDLE;
                end else if (!zero_low_s) begin
                    // Terminal count: a tick in this cycle is ignored, so the count cannot wrap.
                    done_next_s  = 1'b1;
`ifdef CC_ZEROCTRL_AUTORELOAD_EN
                    state_next_s = ST_LOAD;
`else
                    state_next_s = ST_DONE;
`endif
                end else if (CC_ZEROCTRL_tick_In && !CC_ZEROCTRL_pause_In) begin
                    count_next_s = count_r - COUNT_ONE;
                end else begin
                    count_next_s = count_r;
                end
            end
            ST_DONE: begin
                if (CC_ZEROCTRL_abort_In) begin
                    state_next_s = ST_IDLE;
                end else if (CC_ZEROCTRL_start_In) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        busy_next_s = (state_next_s == ST_LOAD) || (state_next_s == ST_COUNT);
    end

    // State, count and registered outputs. Synchronous reset takes priority over all other inputs.
    always_ff @(posedge CC_ZEROCTRL_CLOCK_50) begin
        if (CC_ZEROCTRL_RESET_InHigh) begin
            state_r <= ST_IDLE;
            count_r <= COUNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign CC_ZEROCTRL_count_OutBUS  = count_r;
    assign CC_ZEROCTRL_busy_Out      = busy_r;
    assign CC_ZEROCTRL_done_OutPulse = done_r;
    assign CC_ZEROCTRL_zero_OutLow   = zero_low_s;

endmodule

// File: tb/tb_cc_zero_countdown_ctrl.sv
// Self-checking bench for cc_zero_countdown_ctrl. It applies a table of
// directed vectors, then runs hand-written multi-cycle sequences.
module tb_cc_zero_countdown_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause;
    logic       tick;
    logic [2:0] load;
    logic [2:0] count;
    logic       busy;
    logic       done;
    logic       zero_low;

    int n_cmp;
    int n_err;

    typedef struct {
        logic       rst;
        logic       start;
        logic       abort;
        logic       pause;
        logic       tick;
        logic [2:0] load;
        logic [2:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[$];

    cc_zero_countdown_ctrl #(.ZEROCTRL_DATAWIDTH(3)) dut (
        .CC_ZEROCTRL_CLOCK_50     (clk),
        .CC_ZEROCTRL_RESET_InHigh (rst),
        .CC_ZEROCTRL_start_In     (start),
        .CC_ZEROCTRL_abort_In     (abort),
        .CC_ZEROCTRL_pause_In     (pause),
        .CC_ZEROCTRL_tick_In      (tick),
        .CC_ZEROCTRL_load_InBUS   (load),
        .CC_ZEROCTRL_count_OutBUS (count),
        .CC_ZEROCTRL_busy_Out     (busy),
        .CC_ZEROCTRL_done_OutPulse(done),
        .CC_ZEROCTRL_zero_OutLow  (zero_low)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic a, input logic p,
                         input logic t, input logic [2:0] l);
        rst   = r;
        start = s;
        abort = a;
        pause = p;
        tick  = t;
        load  = l;
    endtask

    // Take one clock edge, then settle so that outputs are sampled away from the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic s, input logic a, input logic p,
                       input logic t, input logic [2:0] l, input logic [2:0] c,
                       input logic b, input logic d, input logic z);
        vec_t v;
        v.rst = r; v.start = s; v.abort = a; v.pause = p; v.tick = t; v.load = l;
        v.exp_count = c; v.exp_busy = b; v.exp_done = d; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    initial begin
        int first_done;
        int pulses;
        int busy_all;
        int win_done;
        n_cmp = 0;
        n_err = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

`ifndef CC_ZEROCTRL_AUTORELOAD_EN
        //  rst   start abort pause tick  load   count busy  done  zero
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0); // reset
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0); // start -> LOAD
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1); // COUNT, count=3
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1); // tick 1
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1); // tick 2
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0); // tick 3 -> 0
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0); // DONE, pulse
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0); // pulse gone
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0); // re-arm, load 0
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0); // COUNT with 0
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0); // DONE, tick ignored
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0); // no wrap to 7
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0); // start+abort -> IDLE
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0); // LOAD 4
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1); // COUNT, start ignored
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1); // paused tick
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 1'b1); // paused tick
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd3, 1'b1, 1'b0, 1'b1); // released tick
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 1'b1, 1'b0, 1'b1); // start while busy
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 3'd3, 1'b0, 1'b0, 1'b1); // abort, holds 3
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 1'b0, 1'b0, 1'b1); // IDLE holds
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd3, 1'b1, 1'b0, 1'b1); // LOAD 5
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1); // COUNT 5
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b0, 1'b1); // tick+abort
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1); // LOAD 5
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 3'd5, 1'b1, 1'b0, 1'b1); // COUNT 5
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0); // reset mid-count
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0); // LOAD max
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1); // COUNT 7
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 3'd6, 1'b1, 1'b0, 1'b1); // tick -> 6

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].pause,
                  vecs[i].tick, vecs[i].load);
            step();
            check($sformatf("v%0d count", i), int'(count), int'(vecs[i].exp_count));
            check($sformatf("v%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
            check($sformatf("v%0d done", i), int'(done), int'(vecs[i].exp_done));
            check($sformatf("v%0d zero_low", i), int'(zero_low), int'(vecs[i].exp_zero));
        end

        // Tick-to-done latency: load 1, a single tick, then watch a bounded window.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1); step();
        check("lat count_loaded", int'(count), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1); step();
        check("lat count_zero", int'(count), 0);
        check("lat done_at_tick", int'(done), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        first_done = -1;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (done) begin
                pulses = pulses + 1;
                if (first_done < 0) first_done = k;
            end
        end
        check("lat first_done_edge", first_done, 1);
        check("lat pulse_count", pulses, 1);
        check("lat busy_final", int'(busy), 0);
        check("lat count_final", int'(count), 0);
`else
        // Auto-reload: load 2, six ticks spaced four cycles apart.
        step();
        check("ar reset count", int'(count), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2); step();
        check("ar count_loaded", int'(count), 2);
        pulses = 0;
        busy_all = 1;
        for (int k = 1; k <= 6; k++) begin
            win_done = 0;
            for (int c = 0; c < 4; c++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, (c == 0) ? 1'b1 : 1'b0, 3'd2);
                step();
                if (done) begin
                    win_done = 1;
                    pulses = pulses + 1;
                end
                if (!busy) busy_all = 0;
            end
            check($sformatf("ar done_after_tick%0d", k), win_done, (k % 2 == 0) ? 1 : 0);
        end
        check("ar pulse_count", pulses, 3);
        check("ar busy_throughout", busy_all, 1);
        check("ar count_reloaded", int'(count), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
